// File: rtl/arq_flow_engine_mlt.sv
// arq_flow_engine_mlt: per-LT ARQ/SEQN/flow engine with retransmit limit and flush timeout.
// Optional build macro ARQ_STATS_EN adds stat_clr_p and the stat_retx/stat_flush/stat_reject counters.
module arq_flow_engine_mlt #(
    parameter int NLT    = 8,
    parameter int LTW    = 3,
    parameter int RETX_W = 4,
    parameter int FLT_W  = 12
) (
    input  logic              clk_6M,
    input  logic              rstz,
    input  logic              conn_new_p,
    input  logic [LTW-1:0]    conn_lt,
    input  logic              slot_p,
    input  logic              rx_endp,
    input  logic              rx_hdr_ok,
    input  logic              rx_lt_addressed,
    input  logic [LTW-1:0]    rx_lt,
    input  logic              rx_data,
    input  logic              rx_nodata,
    input  logic              rx_seqn,
    input  logic              rx_arqn,
    input  logic              rx_flow,
    input  logic              rx_crc_ok,
    input  logic              rx_buf_empty,
    input  logic              tx_req_p,
    input  logic [LTW-1:0]    tx_lt,
    input  logic              tx_data,
    input  logic [RETX_W-1:0] retx_max,
    input  logic [FLT_W-1:0]  flush_to,
    output logic [NLT-1:0]    tx_arqn,
    output logic [NLT-1:0]    tx_seqn,
    output logic [NLT-1:0]    seqn_old,
    output logic [NLT-1:0]    src_flow,
    output logic              rsp_flow,
    output logic              send_new_p,
    output logic              send_old_p,
    output logic              send_zero_p,
    output logic              flush_evt_p
`ifdef ARQ_STATS_EN
    ,
    input  logic              stat_clr_p,
    output logic [15:0]       stat_retx,
    output logic [15:0]       stat_flush,
    output logic [15:0]       stat_reject
`endif
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] OUTST   = 2'd1;
    localparam logic [1:0] FLUSHED = 2'd2;
    logic [NLT-1:0]    tx_arqn_q, tx_arqn_d, tx_seqn_q, tx_seqn_d;
    logic [NLT-1:0]    seqn_old_q, seqn_old_d, src_flow_q, src_flow_d, ack_q, ack_d;
    logic [1:0]        state_q [NLT];
    logic [1:0]        state_d [NLT];
    logic [RETX_W-1:0] retx_q [NLT];
    logic [RETX_W-1:0] retx_d [NLT];
    logic [FLT_W-1:0]  tmr_q [NLT];
    logic [FLT_W-1:0]  tmr_d [NLT];
    logic              send_new_q, send_new_d, send_old_q, send_old_d;
    logic              send_zero_q, send_zero_d, flush_evt_q, flush_evt_d;
    logic              rx_hit, rx_dat, rx_acc, rx_ign, tx_in, tx_ack;
    logic [1:0]        tx_st;
    assign tx_arqn     = tx_arqn_q;
    assign tx_seqn     = tx_seqn_q;
    assign seqn_old    = seqn_old_q;
    assign src_flow    = src_flow_q;
    assign rsp_flow    = rx_buf_empty;
    assign send_new_p  = send_new_q;
    assign send_old_p  = send_old_q;
    assign send_zero_p = send_zero_q;
    assign flush_evt_p = flush_evt_q;
    // Next state: flush/timer first, then RX (so TX sees a same-cycle ack), then TX, then connection init wins.
    always_comb begin
        tx_arqn_d   = tx_arqn_q;
        tx_seqn_d   = tx_seqn_q;
        seqn_old_d  = seqn_old_q;
        src_flow_d  = src_flow_q;
        ack_d       = ack_q;
        state_d     = state_q;
        retx_d      = retx_q;
        tmr_d       = tmr_q;
        flush_evt_d = 1'b0;
        for (int l = 0; l < NLT; l++) begin
            if (state_q[l] == OUTST && ((retx_max != '0 && retx_q[l] == retx_max) ||
                                        (flush_to != '0 && tmr_q[l] >= flush_to))) begin
                state_d[l]  = FLUSHED;
                flush_evt_d = 1'b1;
            end
            if (state_q[l] == OUTST && slot_p && tmr_q[l] != '1)
                tmr_d[l] = tmr_q[l] + FLT_W'(1);
        end
        rx_hit = rx_endp & rx_hdr_ok & rx_lt_addressed & (int'(rx_lt) < NLT);
        rx_dat = rx_data & ~rx_nodata;
        rx_acc = rx_dat & (rx_seqn != seqn_old_q[rx_lt]) & rx_crc_ok;
        rx_ign = rx_dat & (rx_seqn == seqn_old_q[rx_lt]);
        if (rx_hit) begin
            tx_arqn_d[rx_lt]  = rx_acc | rx_ign;
            seqn_old_d[rx_lt] = rx_acc ? rx_seqn : seqn_old_q[rx_lt];
            src_flow_d[rx_lt] = rx_flow;
            ack_d[rx_lt]      = rx_arqn;
        end
        tx_in       = tx_req_p & tx_data & (int'(tx_lt) < NLT);
        tx_st       = state_d[tx_lt];
        tx_ack      = ack_d[tx_lt];
        send_old_d  = tx_in & (tx_st == OUTST) & ~tx_ack;
        send_zero_d = tx_in & (tx_st == FLUSHED);
        send_new_d  = tx_req_p & ~send_old_d & ~send_zero_d;
        if (tx_in && !send_old_d) begin
            tx_seqn_d[tx_lt] = ~tx_seqn_q[tx_lt];
            state_d[tx_lt]   = OUTST;
            retx_d[tx_lt]    = '0;
            tmr_d[tx_lt]     = '0;
            ack_d[tx_lt]     = 1'b0;
        end
        if (send_old_d && retx_q[tx_lt] != '1)
            retx_d[tx_lt] = retx_q[tx_lt] + RETX_W'(1);
        if (conn_new_p && int'(conn_lt) < NLT) begin
            tx_arqn_d[conn_lt]  = 1'b0;
            tx_seqn_d[conn_lt]  = 1'b1;
            seqn_old_d[conn_lt] = 1'b0;
            src_flow_d[conn_lt] = 1'b1;
            ack_d[conn_lt]      = 1'b0;
            state_d[conn_lt]    = IDLE;
            retx_d[conn_lt]     = '0;
            tmr_d[conn_lt]      = '0;
        end
    end
    // State registers; SEQN and remote FLOW come out of reset as all-ones.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            tx_arqn_q   <= '0;
            tx_seqn_q   <= '1;
            seqn_old_q  <= '0;
            src_flow_q  <= '1;
            ack_q       <= '0;
            state_q     <= '{default: IDLE};
            retx_q      <= '{default: '0};
            tmr_q       <= '{default: '0};
            send_new_q  <= 1'b0;
            send_old_q  <= 1'b0;
            send_zero_q <= 1'b0;
            flush_evt_q <= 1'b0;
        end else begin
            tx_arqn_q   <= tx_arqn_d;
            tx_seqn_q   <= tx_seqn_d;
            seqn_old_q  <= seqn_old_d;
            src_flow_q  <= src_flow_d;
            ack_q       <= ack_d;
            state_q     <= state_d;
            retx_q      <= retx_d;
            tmr_q       <= tmr_d;
            send_new_q  <= send_new_d;
            send_old_q  <= send_old_d;
            send_zero_q <= send_zero_d;
            flush_evt_q <= flush_evt_d;
        end
    end
`ifdef ARQ_STATS_EN
    logic [15:0] stat_retx_q, stat_flush_q, stat_reject_q;
    assign stat_retx   = stat_retx_q;
    assign stat_flush  = stat_flush_q;
    assign stat_reject = stat_reject_q;
    // Wrapping event counters over retransmits, flushes and rejected receptions.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            stat_retx_q   <= '0;
            stat_flush_q  <= '0;
            stat_reject_q <= '0;
        end else if (stat_clr_p) begin
            stat_retx_q   <= '0;
            stat_flush_q  <= '0;
            stat_reject_q <= '0;
        end else begin
            stat_retx_q   <= stat_retx_q + 16'(send_old_q);
            stat_flush_q  <= stat_flush_q + 16'(flush_evt_q);
            stat_reject_q <= stat_reject_q + 16'(rx_hit & ~rx_acc & ~rx_ign);
        end
    end
`endif
endmodule

// File: tb/tb_arq_flow_engine_mlt.sv
// tb_arq_flow_engine_mlt: vector table, corner sequences and random traffic against a per-LT reference model.
module tb_arq_flow_engine_mlt;
    logic        clk_6M = 1'b0, rstz = 1'b0;
    logic        conn_new_p = 0, slot_p = 0, rx_endp = 0, rx_hdr_ok = 0, rx_lt_addressed = 0;
    logic [2:0]  conn_lt = 0, rx_lt = 0, tx_lt = 0;
    logic        rx_data = 0, rx_nodata = 0, rx_seqn = 0, rx_arqn = 0, rx_flow = 0, rx_crc_ok = 0;
    logic        rx_buf_empty = 1, tx_req_p = 0, tx_data = 0;
    logic [3:0]  retx_max = 0;
    logic [11:0] flush_to = 0;
    logic [7:0]  tx_arqn, tx_seqn, seqn_old, src_flow;
    logic        rsp_flow, send_new_p, send_old_p, send_zero_p, flush_evt_p;

    arq_flow_engine_mlt dut (
        .clk_6M(clk_6M), .rstz(rstz), .conn_new_p(conn_new_p), .conn_lt(conn_lt), .slot_p(slot_p),
        .rx_endp(rx_endp), .rx_hdr_ok(rx_hdr_ok), .rx_lt_addressed(rx_lt_addressed), .rx_lt(rx_lt),
        .rx_data(rx_data), .rx_nodata(rx_nodata), .rx_seqn(rx_seqn), .rx_arqn(rx_arqn), .rx_flow(rx_flow),
        .rx_crc_ok(rx_crc_ok), .rx_buf_empty(rx_buf_empty), .tx_req_p(tx_req_p), .tx_lt(tx_lt),
        .tx_data(tx_data), .retx_max(retx_max), .flush_to(flush_to), .tx_arqn(tx_arqn), .tx_seqn(tx_seqn),
        .seqn_old(seqn_old), .src_flow(src_flow), .rsp_flow(rsp_flow), .send_new_p(send_new_p),
        .send_old_p(send_old_p), .send_zero_p(send_zero_p), .flush_evt_p(flush_evt_p)
    );

    always #5 clk_6M = ~clk_6M;

    int n_cmp = 0, n_bad = 0;
    bit [7:0] m_arqn, m_seqn, m_old, m_flow, m_ack;
    int m_st [8];
    int m_retx [8];
    int m_tmr [8];
    bit e_new, e_old, e_zero, e_flush;

    typedef struct {
        bit hdr, addr; bit [2:0] lt; bit data, seqn, crc, flow, buf_e;
        bit e_arqn, e_old, e_flow;
    } rxv_t;
    rxv_t tbl [8];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [63:0] dut_vec();
        return {27'd0, tx_arqn, tx_seqn, seqn_old, src_flow, rsp_flow,
                send_new_p, send_old_p, send_zero_p, flush_evt_p};
    endfunction

    function automatic logic [63:0] exp_vec();
        return {27'd0, m_arqn, m_seqn, m_old, m_flow, rx_buf_empty, e_new, e_old, e_zero, e_flush};
    endfunction

    task automatic model_conn(input int t);
        m_arqn[t] = 0; m_seqn[t] = 1; m_old[t] = 0; m_flow[t] = 1; m_ack[t] = 0;
        m_st[t] = 0; m_retx[t] = 0; m_tmr[t] = 0;
    endtask

    // Per-LT state: 0 idle, 1 payload outstanding, 2 flushed.
    task automatic model_update();
        int t;
        bit was_out;
        e_new = 0; e_old = 0; e_zero = 0; e_flush = 0;
        for (int l = 0; l < 8; l++) begin
            was_out = (m_st[l] == 1);
            if (was_out && ((retx_max != 0 && m_retx[l] >= int'(retx_max)) ||
                            (flush_to != 0 && m_tmr[l] >= int'(flush_to)))) begin
                m_st[l] = 2;
                e_flush = 1;
            end
            if (was_out && slot_p) m_tmr[l] = (m_tmr[l] < 4095) ? m_tmr[l] + 1 : 4095;
        end
        if (rx_endp && rx_hdr_ok && rx_lt_addressed) begin
            t = int'(rx_lt);
            if (rx_data && rx_seqn != m_old[t] && rx_crc_ok) begin
                m_arqn[t] = 1;
                m_old[t] = rx_seqn;
            end else m_arqn[t] = (rx_data && rx_seqn == m_old[t]);
            m_flow[t] = rx_flow;
            m_ack[t] = rx_arqn;
        end
        if (tx_req_p) begin
            t = int'(tx_lt);
            if (!tx_data) e_new = 1;
            else if (m_st[t] == 1 && !m_ack[t]) begin
                e_old = 1;
                m_retx[t] = (m_retx[t] < 15) ? m_retx[t] + 1 : 15;
            end else begin
                if (m_st[t] == 2) e_zero = 1; else e_new = 1;
                m_seqn[t] = ~m_seqn[t];
                m_st[t] = 1; m_retx[t] = 0; m_tmr[t] = 0; m_ack[t] = 0;
            end
        end
        if (conn_new_p) model_conn(int'(conn_lt));
    endtask

    task automatic step();
        @(posedge clk_6M);
        model_update();
        #1;
        chk("model", dut_vec(), exp_vec());
        {rx_endp, tx_req_p, slot_p, conn_new_p} = '0;
    endtask

    task automatic conn(input logic [2:0] lt);
        conn_new_p = 1; conn_lt = lt;
        step();
    endtask

    task automatic txreq(input logic [2:0] lt, input logic d);
        tx_req_p = 1; tx_lt = lt; tx_data = d;
        step();
    endtask

    task automatic rx(input bit hdr, input bit addr, input logic [2:0] lt, input bit data,
                      input bit seqn, input bit crc, input bit flow);
        rx_endp = 1; rx_hdr_ok = hdr; rx_lt_addressed = addr; rx_lt = lt; rx_data = data;
        rx_nodata = ~data; rx_seqn = seqn; rx_crc_ok = crc; rx_flow = flow; rx_arqn = 0;
        step();
    endtask

    initial begin
        bit seen;
        tbl[0] = '{1,1,1, 1,1,1,1,1, 1,1,1};
        tbl[1] = '{1,1,1, 1,1,1,1,1, 1,1,1};
        tbl[2] = '{1,1,1, 1,0,0,1,1, 0,1,1};
        tbl[3] = '{0,1,1, 1,0,1,0,1, 0,1,1};
        tbl[4] = '{1,1,1, 1,0,1,1,1, 1,0,1};
        tbl[5] = '{1,0,1, 1,1,1,0,1, 1,0,1};
        tbl[6] = '{1,1,1, 0,1,1,1,1, 0,0,1};
        tbl[7] = '{1,1,3, 0,0,1,0,0, 0,0,0};
        for (int l = 0; l < 8; l++) model_conn(l);
        m_seqn = '1;
        repeat (3) @(posedge clk_6M);
        #1 rstz = 1;
        chk("reset", dut_vec(), {27'd0, 8'h00, 8'hFF, 8'h00, 8'hFF, 1'b1, 4'b0000});
        conn(3'd1);
        foreach (tbl[i]) begin
            rx_buf_empty = tbl[i].buf_e;
            rx(tbl[i].hdr, tbl[i].addr, tbl[i].lt, tbl[i].data, tbl[i].seqn, tbl[i].crc, tbl[i].flow);
            chk($sformatf("rx_vec%0d", i), {tx_arqn[tbl[i].lt], seqn_old[tbl[i].lt], src_flow[tbl[i].lt], rsp_flow},
                {tbl[i].e_arqn, tbl[i].e_old, tbl[i].e_flow, tbl[i].buf_e});
        end
        rx_buf_empty = 1;
        rx(1, 1, 3'd2, 1, 1, 1, 0);
        txreq(3'd2, 1);
        chk("lt2_before_conn", {tx_arqn[2], tx_seqn[2], seqn_old[2], src_flow[2]}, 4'b1010);
        conn(3'd2);
        chk("lt2_conn_new", {tx_arqn[2], tx_seqn[2], seqn_old[2], src_flow[2]}, 4'b0101);
        retx_max = 3;
        conn(3'd4);
        txreq(3'd4, 1);
        chk("retx_first_new", {send_new_p, send_old_p, send_zero_p}, 3'b100);
        chk("retx_seqn_toggle", tx_seqn[4], 1'b0);
        for (int i = 0; i < 3; i++) begin
            txreq(3'd4, 1);
            chk($sformatf("retx_old%0d", i), {send_new_p, send_old_p, send_zero_p, flush_evt_p}, 4'b0100);
        end
        step();
        chk("retx_flush_evt", flush_evt_p, 1'b1);
        txreq(3'd4, 1);
        chk("retx_zero", {send_new_p, send_old_p, send_zero_p}, 3'b001);
        chk("retx_zero_seqn", tx_seqn[4], 1'b1);
        retx_max = 0; flush_to = 5;
        conn(3'd4);
        conn(3'd5);
        txreq(3'd5, 1);
        for (int i = 0; i < 4; i++) begin
            slot_p = 1;
            step();
            chk($sformatf("tmr_noflush%0d", i), flush_evt_p, 1'b0);
        end
        step();
        chk("tmr_noflush_idle", flush_evt_p, 1'b0);
        slot_p = 1;
        step();
        seen = flush_evt_p;
        for (int i = 0; i < 3 && !seen; i++) begin
            step();
            seen = flush_evt_p;
        end
        chk("tmr_flush_evt", seen, 1'b1);
        for (int c = 0; c < 3000; c++) begin
            if (c % 256 == 0) begin
                retx_max = 4'($urandom_range(0, 4));
                flush_to = 12'($urandom_range(0, 8));
            end
            conn_new_p = ($urandom_range(0, 49) == 0); conn_lt = 3'($urandom);
            slot_p = ($urandom_range(0, 3) == 0);
            rx_endp = ($urandom_range(0, 2) == 0);
            rx_hdr_ok = ($urandom_range(0, 7) != 0); rx_lt_addressed = ($urandom_range(0, 7) != 0);
            rx_lt = 3'($urandom); rx_data = 1'($urandom); rx_nodata = ~rx_data;
            rx_seqn = 1'($urandom); rx_arqn = 1'($urandom); rx_flow = 1'($urandom);
            rx_crc_ok = ($urandom_range(0, 3) != 0); rx_buf_empty = 1'($urandom);
            tx_req_p = ($urandom_range(0, 2) == 0); tx_lt = 3'($urandom);
            tx_data = ($urandom_range(0, 4) != 0);
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
